// File: rtl/door_motor_if.sv
// Command/status bundle between the push-button door controller (master)
// and the motor-side drive (slave). The controller issues level commands
// M_CW/M_ACW and observes bridge drives, door position and status flags.
interface door_motor_if #(
  parameter int POS_W = 8
);
  logic             M_CW;
  logic             M_ACW;
  logic             DRV_CW;
  logic             DRV_ACW;
  logic [POS_W-1:0] POS;
  logic             LIM_OPEN;
  logic             LIM_CLOSED;
  logic             BUSY;
  logic             FAULT;

  modport master (
    output M_CW, M_ACW,
    input  DRV_CW, DRV_ACW, POS, LIM_OPEN, LIM_CLOSED, BUSY, FAULT
  );

  modport slave (
    input  M_CW, M_ACW,
    output DRV_CW, DRV_ACW, POS, LIM_OPEN, LIM_CLOSED, BUSY, FAULT
  );
endinterface

// File: rtl/door_motor_drive.sv
// Motor-side door drive: turns open/close level commands into bridge drives
// with break-before-make dead-time, tracks door position as a travel count
// (0 = closed, TRAVEL = open) and reports limit/busy/fault status.
// Optional build macro DOOR_AUTO_CLOSE_EN: after the door has sat open and
// uncommanded for HOLD cycles it closes by itself.
module door_motor_drive #(
  parameter int TRAVEL = 16,
  parameter int DEAD   = 4,
  parameter int POS_W  = 8,
  parameter int HOLD   = 32
) (
  input  logic        CLK,
  input  logic        RST,
  door_motor_if.slave bus
);

  // Elaboration-time sanity check on the parameter set.
  if (TRAVEL < 1 || TRAVEL > (2**POS_W) - 1 || DEAD < 1 || HOLD < 1) begin : g_param_check
    $error("door_motor_drive: illegal parameter set");
  end

  localparam int               CW       = $clog2(DEAD + 1);
  localparam logic [CW-1:0]    DEAD_LD  = CW'(DEAD - 1);
  localparam logic [POS_W-1:0] TRAVEL_P = POS_W'(TRAVEL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN_CW,
    S_RUN_ACW,
    S_DEADTIME,
    S_FAULT
  } state_t;

  state_t           state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [CW-1:0]    dead_q, dead_d;
  logic             drv_cw_q, drv_cw_d;
  logic             drv_acw_q, drv_acw_d;
  logic             busy_q, busy_d;
  logic             fault_q, fault_d;
  logic             decide;
  logic             stop_acw;

`ifdef DOOR_AUTO_CLOSE_EN
  localparam int            HW      = $clog2(HOLD + 1);
  localparam logic [HW-1:0] HOLD_LD = HW'(HOLD - 1);
  logic [HW-1:0] hold_q, hold_d;
  logic          auto_q, auto_d;
`endif

  // Next-state, position, dead-time and hold-timer logic.
  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    dead_d   = dead_q;
    decide   = 1'b0;
    stop_acw = bus.M_CW || !bus.M_ACW;
`ifdef DOOR_AUTO_CLOSE_EN
    hold_d = hold_q;
    auto_d = auto_q;
    // An automatic close runs without M_ACW held; any command interrupts it.
    if (auto_q) stop_acw = bus.M_CW || bus.M_ACW;
`endif
    case (state_q)
      S_IDLE: decide = 1'b1;
      S_RUN_CW: begin
        if (bus.M_ACW || !bus.M_CW) begin
          state_d = S_DEADTIME;
          dead_d  = DEAD_LD;
        end else begin
          pos_d = pos_q + POS_W'(1);
          // Stopping on the limit needs no dead-time.
          if (pos_q + POS_W'(1) == TRAVEL_P) state_d = S_IDLE;
        end
      end
      S_RUN_ACW: begin
        if (stop_acw) begin
          state_d = S_DEADTIME;
          dead_d  = DEAD_LD;
        end else begin
          pos_d = pos_q - POS_W'(1);
          if (pos_q == POS_W'(1)) state_d = S_IDLE;
        end
      end
      S_DEADTIME: begin
        // The final dead cycle hands straight over to the idle decision.
        if (dead_q == '0) decide = 1'b1;
        else              dead_d = dead_q - CW'(1);
      end
      S_FAULT: begin
        if (!bus.M_CW && !bus.M_ACW) begin
          state_d = S_DEADTIME;
          dead_d  = DEAD_LD;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (decide) begin
      state_d = S_IDLE;
      if (bus.M_CW && bus.M_ACW)             state_d = S_FAULT;
      else if (bus.M_CW && pos_q < TRAVEL_P) state_d = S_RUN_CW;
      else if (bus.M_ACW && pos_q != '0)     state_d = S_RUN_ACW;
`ifdef DOOR_AUTO_CLOSE_EN
      else if (state_q == S_IDLE && pos_q == TRAVEL_P) begin
        if (bus.M_CW || bus.M_ACW) hold_d = HOLD_LD;
        else if (hold_q == '0) begin
          state_d = S_RUN_ACW;
          auto_d  = 1'b1;
        end else hold_d = hold_q - HW'(1);
      end
`endif
    end

`ifdef DOOR_AUTO_CLOSE_EN
    if (state_d == S_IDLE && state_q != S_IDLE && pos_d == TRAVEL_P) hold_d = HOLD_LD;
    if (state_d != S_RUN_ACW) auto_d = 1'b0;
`endif

    drv_cw_d  = (state_d == S_RUN_CW);
    drv_acw_d = (state_d == S_RUN_ACW);
    busy_d    = (state_d != S_IDLE);
    fault_d   = (state_d == S_FAULT);
  end

  // State and registered outputs; drives are decoded from the next state so
  // they come straight from flops and can never be high together.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      pos_q     <= '0;
      dead_q    <= '0;
      drv_cw_q  <= 1'b0;
      drv_acw_q <= 1'b0;
      busy_q    <= 1'b0;
      fault_q   <= 1'b0;
`ifdef DOOR_AUTO_CLOSE_EN
      hold_q    <= '0;
      auto_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      dead_q    <= dead_d;
      drv_cw_q  <= drv_cw_d;
      drv_acw_q <= drv_acw_d;
      busy_q    <= busy_d;
      fault_q   <= fault_d;
`ifdef DOOR_AUTO_CLOSE_EN
      hold_q    <= hold_d;
      auto_q    <= auto_d;
`endif
    end
  end

  assign bus.DRV_CW     = drv_cw_q;
  assign bus.DRV_ACW    = drv_acw_q;
  assign bus.POS        = pos_q;
  assign bus.BUSY       = busy_q;
  assign bus.FAULT      = fault_q;
  assign bus.LIM_OPEN   = (pos_q == TRAVEL_P);
  assign bus.LIM_CLOSED = (pos_q == '0);

endmodule

// File: tb/tb_door_motor_drive.sv
// Directed scenarios plus randomized command traffic for door_motor_drive,
// checked every cycle against a behavioural door model.
module tb_door_motor_drive;

  localparam int TRAVEL = 16;
  localparam int DEAD   = 4;
  localparam int POS_W  = 8;
  localparam int HOLD   = 32;

  localparam int MD_IDLE  = 0;
  localparam int MD_OPEN  = 1;
  localparam int MD_CLOSE = 2;
  localparam int MD_DEAD  = 3;
  localparam int MD_FAULT = 4;

  logic CLK;
  logic RST;
  int   checks;
  int   failures;

  door_motor_if #(.POS_W(POS_W)) dif ();

  door_motor_drive #(
    .TRAVEL(TRAVEL), .DEAD(DEAD), .POS_W(POS_W), .HOLD(HOLD)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(dif.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural door: what mode it is in, where it is, how long it has been
  // in dead-time, and how long it has sat open with no command.
  int m_mode;
  int m_pos;
  int m_dead;
  bit m_auto;
`ifdef DOOR_AUTO_CLOSE_EN
  int m_quiet;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic enter_dead();
    m_mode = MD_DEAD;
    m_dead = 1;
  endtask

  task automatic idle_rules(input bit cw, input bit acw);
    if (cw && acw)                m_mode = MD_FAULT;
    else if (cw && m_pos < TRAVEL) m_mode = MD_OPEN;
    else if (acw && m_pos > 0)    m_mode = MD_CLOSE;
    else                          m_mode = MD_IDLE;
  endtask

  task automatic model_edge(input bit cw, input bit acw, input bit rst);
    int  prev;
    bit  stop;
    prev = m_mode;
    if (rst) begin
      m_mode = MD_IDLE; m_pos = 0; m_dead = 0; m_auto = 0;
`ifdef DOOR_AUTO_CLOSE_EN
      m_quiet = 0;
`endif
      return;
    end
    case (prev)
      MD_IDLE: begin
        idle_rules(cw, acw);
`ifdef DOOR_AUTO_CLOSE_EN
        if (m_mode == MD_IDLE && m_pos == TRAVEL) begin
          if (cw || acw) m_quiet = 1;
          else if (m_quiet == HOLD) begin m_mode = MD_CLOSE; m_auto = 1; end
          else m_quiet++;
        end
`endif
      end
      MD_OPEN: begin
        if (acw || !cw) enter_dead();
        else begin
          m_pos++;
          if (m_pos == TRAVEL) m_mode = MD_IDLE;
        end
      end
      MD_CLOSE: begin
        stop = m_auto ? (cw || acw) : (cw || !acw);
        if (stop) enter_dead();
        else begin
          m_pos--;
          if (m_pos == 0) m_mode = MD_IDLE;
        end
      end
      MD_DEAD: begin
        if (m_dead == DEAD) idle_rules(cw, acw);
        else m_dead++;
      end
      default: if (!cw && !acw) enter_dead();
    endcase
    if (m_mode != MD_CLOSE) m_auto = 0;
`ifdef DOOR_AUTO_CLOSE_EN
    if (m_mode == MD_IDLE && prev != MD_IDLE && m_pos == TRAVEL) m_quiet = 1;
`endif
  endtask

  task automatic check_model(input string tag);
    logic [31:0] obs, exp;
    obs = {18'd0, dif.DRV_CW, dif.DRV_ACW, dif.LIM_OPEN, dif.LIM_CLOSED,
           dif.BUSY, dif.FAULT, dif.POS};
    exp = {18'd0, m_mode == MD_OPEN, m_mode == MD_CLOSE, m_pos == TRAVEL, m_pos == 0,
           m_mode != MD_IDLE, m_mode == MD_FAULT, POS_W'(m_pos)};
    chk(tag, obs, exp);
  endtask

  // One clock: apply inputs, step DUT and model on the edge, compare after it.
  task automatic cyc(input bit cw, input bit acw, input bit rst, input string tag);
    dif.M_CW  = cw;
    dif.M_ACW = acw;
    RST       = rst;
    @(posedge CLK);
    model_edge(cw, acw, rst);
    #1;
    check_model(tag);
  endtask

  initial begin
    int n, first, dead, fcnt, acw_seen, sel;
    bit cw, acw;
    checks = 0; failures = 0;
    m_mode = MD_IDLE; m_pos = 0; m_dead = 0; m_auto = 0;
`ifdef DOOR_AUTO_CLOSE_EN
    m_quiet = 0;
`endif
    dif.M_CW = 1'b0; dif.M_ACW = 1'b0; RST = 1'b1;

    // Reset state
    cyc(0, 0, 1, "m_reset");
    cyc(0, 0, 1, "m_reset");
    chk("reset_pos", 32'(dif.POS), 0);
    chk("reset_flags", 32'({dif.DRV_CW, dif.DRV_ACW, dif.LIM_OPEN, dif.LIM_CLOSED, dif.BUSY, dif.FAULT}), 32'b000100);

    // Full open stroke with M_CW held for 30 cycles
    n = 0; first = -1; acw_seen = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(1, 0, 0, "m_t1");
      if (dif.DRV_CW) begin n++; if (first < 0) first = i; end
      if (dif.DRV_ACW) acw_seen = 1;
    end
    chk("t1_drive_cycles", 32'(n), 16);
    chk("t1_first_drive", 32'(first), 0);
    chk("t1_pos", 32'(dif.POS), 16);
    chk("t1_lim_open", 32'(dif.LIM_OPEN), 1);
    chk("t1_busy", 32'(dif.BUSY), 0);
    chk("t1_no_acw", 32'(acw_seen), 0);

    // Six-cycle close pulse from open, then dead-time
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, "m_t2");
    chk("t2_pos_after_pulse", 32'(dif.POS), 11);
    dead = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 0, "m_t2");
      if (dif.BUSY && !dif.DRV_CW && !dif.DRV_ACW) dead++;
      else break;
    end
    chk("t2_dead_cycles", 32'(dead), 4);
    chk("t2_pos_idle", 32'(dif.POS), 11);
    chk("t2_busy_idle", 32'(dif.BUSY), 0);

    // Reversal at POS=8 while opening
    for (int i = 0; i < 40 && !(dif.POS == 0 && !dif.BUSY); i++) cyc(0, 1, 0, "m_t3");
    chk("t3_closed", 32'(dif.POS), 0);
    for (int i = 0; i < 9; i++) cyc(1, 0, 0, "m_t3");
    chk("t3_pos_at_rev", 32'(dif.POS), 8);
    chk("t3_running_cw", 32'(dif.DRV_CW), 1);
    dead = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 0, "m_t3");
      if (dif.DRV_ACW) break;
      if (!dif.DRV_CW) dead++;
    end
    chk("t3_dead_cycles", 32'(dead), 4);
    chk("t3_pos_at_acw_start", 32'(dif.POS), 8);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, "m_t3");
    chk("t3_pos_falling", 32'(dif.POS), 5);
    for (int i = 0; i < 20 && dif.BUSY; i++) cyc(0, 0, 0, "m_t3");

    // Conflicting commands from idle
    cyc(1, 1, 0, "m_t4");
    chk("t4_fault_set", 32'({dif.FAULT, dif.DRV_CW, dif.DRV_ACW}), 32'b100);
    fcnt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1, 1, 0, "m_t4");
      if (dif.FAULT) fcnt++;
    end
    chk("t4_fault_held", 32'(fcnt), 10);
    dead = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 0, "m_t4");
      if (dif.FAULT) break;
      if (dif.BUSY) dead++;
      else break;
    end
    chk("t4_dead_cycles", 32'(dead), 4);
    chk("t4_fault_clear", 32'(dif.FAULT), 0);
    chk("t4_pos_kept", 32'(dif.POS), 5);

    // Reset mid-motion re-homes the door
    for (int i = 0; i < 40 && !(dif.POS == 0 && !dif.BUSY); i++) cyc(0, 1, 0, "m_t5");
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, "m_t5");
    chk("t5_pos_before_rst", 32'(dif.POS), 5);
    cyc(1, 0, 1, "m_t5");
    chk("t5_after_rst", 32'({dif.DRV_CW, dif.DRV_ACW, dif.LIM_CLOSED, dif.BUSY, POS_W'(dif.POS)}), 32'({4'b0010, 8'd0}));
    acw_seen = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, "m_t5");
      if (dif.DRV_ACW || dif.BUSY) acw_seen = 1;
    end
    chk("t5_no_close_at_zero", 32'(acw_seen), 0);

    // Randomized command traffic against the model
    cw = 0; acw = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        sel = $urandom_range(0, 9);
        cw  = (sel < 3) || (sel == 9);
        acw = (sel >= 3 && sel < 6) || (sel == 9);
      end
      cyc(cw, acw, $urandom_range(0, 399) == 0, "m_rand");
    end

`ifdef DOOR_AUTO_CLOSE_EN
    // Auto-close after HOLD idle cycles at the open limit
    cyc(0, 0, 1, "m_t6");
    for (int i = 0; i < 20; i++) cyc(1, 0, 0, "m_t6");
    first = -1;
    for (int i = 1; i <= 40; i++) begin
      cyc(0, 0, 0, "m_t6");
      if (dif.DRV_ACW) begin first = i; break; end
    end
    chk("t6_close_start", 32'(first), 32);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      cyc(0, 0, 0, "m_t6");
      if (dif.DRV_ACW) n++;
      else break;
    end
    chk("t6_close_cycles", 32'(n), 16);
    chk("t6_pos_closed", 32'(dif.POS), 0);

    // A command pulse while waiting restarts the hold time
    for (int i = 0; i < 20; i++) cyc(1, 0, 0, "m_t6");
    acw_seen = 0;
    for (int i = 0; i < 19; i++) begin
      cyc(0, 0, 0, "m_t6");
      if (dif.DRV_ACW) acw_seen = 1;
    end
    chk("t6_no_early_close", 32'(acw_seen), 0);
    cyc(1, 0, 0, "m_t6");
    first = -1;
    for (int i = 1; i <= 40; i++) begin
      cyc(0, 0, 0, "m_t6");
      if (dif.DRV_ACW) begin first = i; break; end
    end
    chk("t6_close_after_reload", 32'(first), 32);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
